// File: rtl/br_predictor_if.sv
// Fetch-lookup and execute-resolve signal bundle for the branch predictor.
// The master side is the pipeline; the slave side is the predictor.
interface br_predictor_if #(
    parameter int DATAW = 32
);
    logic [DATAW-1:0] if_pc;
    logic             pred_taken;
    logic [DATAW-1:0] pred_target;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [DATAW-1:0] ex_pc;
    logic [DATAW-1:0] ex_target;
    logic             ex_taken;
    logic             ex_pred_taken;
    logic [DATAW-1:0] ex_pred_target;
    logic             mispredict;
    logic [DATAW-1:0] redirect_pc;
    logic [DATAW-1:0] br_count;
    logic [DATAW-1:0] miss_count;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_pc, ex_target,
               ex_taken, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               br_count, miss_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_target,
               ex_taken, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               br_count, miss_count
    );
endinterface

// File: rtl/br_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, combinational
// fetch lookup, execute-stage update, mispredict/redirect and perf counters.
module br_predictor #(
    parameter int DATAW   = 32,
    parameter int ENTRIES = 16
) (
    input logic         clk,
    input logic         rst,
    br_predictor_if.slave bp
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = DATAW - IDXW - 2;

    logic [ENTRIES-1:0] valid;
    logic [1:0]         ctr     [ENTRIES];
    logic [TAGW-1:0]    tag_mem [ENTRIES];
    logic [DATAW-1:0]   tgt_mem [ENTRIES];

    logic [IDXW-1:0] if_idx;
    logic [TAGW-1:0] if_tag;
    logic            if_hit;
    logic [IDXW-1:0] ex_idx;
    logic [TAGW-1:0] ex_tag;
    logic            ex_hit;
    logic            upd;

    always_comb begin
        if_idx = bp.if_pc[IDXW+1:2];
        if_tag = bp.if_pc[DATAW-1:IDXW+2];
        if_hit = valid[if_idx] && (tag_mem[if_idx] == if_tag);
        bp.pred_taken  = if_hit && ctr[if_idx][1];
        bp.pred_target = bp.pred_taken ? tgt_mem[if_idx] : '0;
    end

    always_comb begin
        upd    = bp.ex_valid && bp.ex_is_branch;
        ex_idx = bp.ex_pc[IDXW+1:2];
        ex_tag = bp.ex_pc[DATAW-1:IDXW+2];
        ex_hit = valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);
        bp.mispredict = upd && ((bp.ex_taken != bp.ex_pred_taken) ||
                        (bp.ex_taken && bp.ex_pred_taken &&
                         (bp.ex_target != bp.ex_pred_target)));
        bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + DATAW'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (upd) begin
            if (ex_hit) begin
                if (bp.ex_taken) begin
                    ctr[ex_idx] <= (ctr[ex_idx] == 2'b11) ? 2'b11 : ctr[ex_idx] + 2'd1;
                end else begin
                    ctr[ex_idx] <= (ctr[ex_idx] == 2'b00) ? 2'b00 : ctr[ex_idx] - 2'd1;
                end
            end else if (bp.ex_taken) begin
                valid[ex_idx] <= 1'b1;
                ctr[ex_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target need no reset; a taken resolution writes both whether it hits
    // (tag unchanged) or allocates.
    always_ff @(posedge clk) begin
        if (!rst && upd && bp.ex_taken) begin
            tag_mem[ex_idx] <= ex_tag;
            tgt_mem[ex_idx] <= bp.ex_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp.br_count   <= '0;
            bp.miss_count <= '0;
        end else begin
            if (upd) begin
                bp.br_count <= bp.br_count + DATAW'(1);
            end
            if (bp.mispredict) begin
                bp.miss_count <= bp.miss_count + DATAW'(1);
            end
        end
    end
endmodule

// File: tb/tb_br_predictor.sv
// Scoreboard bench for br_predictor: stimulus pushes expectations from a
// line-address reference model; a negedge monitor pops and compares.
module tb_br_predictor;
    localparam int DATAW   = 32;
    localparam int ENTRIES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    br_predictor_if #(.DATAW(DATAW)) bus ();

    br_predictor #(.DATAW(DATAW), .ENTRIES(ENTRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus.slave)
    );

    typedef struct {
        bit          pt;
        logic [31:0] ptgt;
        bit          mp;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: each slot remembers the full word address (pc>>2)
    bit          m_v    [ENTRIES];
    logic [29:0] m_line [ENTRIES];
    logic [31:0] m_tgt  [ENTRIES];
    int          m_c    [ENTRIES];
    logic [31:0] m_br, m_miss;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i] = 0;
            m_c[i] = 1;
        end
        m_br   = 0;
        m_miss = 0;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int slot = int'((pc >> 2) % ENTRIES);
        return m_v[slot] && (m_line[slot] == pc[31:2]);
    endfunction

    function automatic void model_pred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
        int slot = int'((pc >> 2) % ENTRIES);
        t  = model_hit(pc) && (m_c[slot] >= 2);
        tg = t ? m_tgt[slot] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pred_taken", 32'(bus.pred_taken), 32'(e.pt));
                check("pred_target", bus.pred_target, e.ptgt);
                check("mispredict", 32'(bus.mispredict), 32'(e.mp));
                if (e.mp) check("redirect_pc", bus.redirect_pc, e.rpc);
                check("br_count", bus.br_count, e.bc);
                check("miss_count", bus.miss_count, e.mc);
            end
        end
    end

    // Drive one cycle, record what the DUT must show before the next edge,
    // then advance the model past that edge.
    task automatic step(input logic [31:0] ifpc, input bit v, input bit b,
                        input logic [31:0] expc, input logic [31:0] tgt, input bit tk,
                        input bit ptk, input logic [31:0] ptgt);
        exp_t e;
        bit   upd, mp, hit;
        int   slot;
        @(posedge clk);
        #1;
        bus.if_pc = ifpc;  bus.ex_valid = v;  bus.ex_is_branch = b;
        bus.ex_pc = expc;  bus.ex_target = tgt; bus.ex_taken = tk;
        bus.ex_pred_taken = ptk; bus.ex_pred_target = ptgt;
        upd = v && b;
        mp  = upd && ((tk != ptk) || (tk && ptk && tgt != ptgt));
        model_pred(ifpc, e.pt, e.ptgt);
        e.mp  = mp;
        e.rpc = tk ? tgt : expc + 32'd4;
        e.bc  = m_br;
        e.mc  = m_miss;
        q.push_back(e);
        if (upd) begin
            slot = int'((expc >> 2) % ENTRIES);
            hit  = model_hit(expc);
            m_br++;
            if (mp) m_miss++;
            if (hit && tk) begin
                m_c[slot]   = (m_c[slot] < 3) ? m_c[slot] + 1 : 3;
                m_tgt[slot] = tgt;
            end else if (hit) begin
                m_c[slot] = (m_c[slot] > 0) ? m_c[slot] - 1 : 0;
            end else if (tk) begin
                m_v[slot]    = 1;
                m_line[slot] = expc[31:2];
                m_tgt[slot]  = tgt;
                m_c[slot]    = 2;
            end
        end
    endtask

    task automatic idle(input logic [31:0] ifpc);
        step(ifpc, 0, 1, 32'h0, 32'h0, 0, 0, 32'h0);
    endtask

    // Resolution whose carried prediction is what the model predicts for ex_pc
    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
        bit          ptk;
        logic [31:0] ptgt;
        model_pred(pc, ptk, ptgt);
        step(pc, 1, 1, pc, tgt, tk, ptk, ptgt);
    endtask

    initial begin
        bit          ptk;
        logic [31:0] ptgt, pc, tgt;
        int          drain;
        bus.if_pc = '0; bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_pc = '0;
        bus.ex_target = '0; bus.ex_taken = 0; bus.ex_pred_taken = 0; bus.ex_pred_target = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        idle(32'h100);
        step(32'h100, 1, 1, 32'h100, 32'h80, 1, 0, 32'h0);
        idle(32'h100);
        resolve(32'h100, 32'h80, 1);
        resolve(32'h100, 32'h80, 1);
        idle(32'h100);
        for (int i = 0; i < 5; i++) begin
            resolve(32'h100, 32'h80, 0);
            idle(32'h100);
        end
        resolve(32'h100, 32'h80, 1);
        idle(32'h100);

        step(32'h0, 1, 1, 32'h200, 32'h0, 0, 1, 32'h240);
        step(32'h0, 1, 1, 32'hFFFF_FFFC, 32'h0, 0, 1, 32'h10);

        step(32'h400, 1, 1, 32'h400, 32'h40, 1, 0, 32'h0);
        step(32'h400, 1, 1, 32'h400, 32'h60, 1, 1, 32'h40);
        idle(32'h400);
        resolve(32'h100, 32'h80, 1);
        resolve(32'h100, 32'h80, 1);
        idle(32'h100);
        resolve(32'h100 + 4 * ENTRIES, 32'h900, 1);
        idle(32'h100);
        idle(32'h100 + 4 * ENTRIES);

        resolve(32'h300, 32'h500, 1);
        idle(32'h300);
        step(32'h300, 0, 1, 32'h300, 32'h500, 1, 0, 32'h0);
        step(32'h300, 1, 0, 32'h300, 32'h500, 1, 0, 32'h0);
        idle(32'h300);

        // Reset raised between edges must clear outputs before the next edge
        @(posedge clk);
        #1;
        bus.if_pc = 32'h300; bus.ex_valid = 0;
        #2 rst = 1'b1;
        model_reset();
        q.push_back('{pt: 0, ptgt: 32'h0, mp: 0, rpc: 32'h0, bc: 32'h0, mc: 32'h0});
        @(posedge clk);
        #1 rst = 1'b0;
        idle(32'h300);

        for (int i = 0; i < 400; i++) begin
            pc  = 32'h1000 + 32'($urandom_range(0, 2)) * 4 * ENTRIES
                + 32'($urandom_range(0, ENTRIES - 1)) * 4 + 32'($urandom_range(0, 3));
            tgt = 32'h8000 + 32'($urandom_range(0, 3)) * 16;
            model_pred(pc, ptk, ptgt);
            if ($urandom_range(0, 3) == 0) ptk = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 3) == 0) ptgt = tgt;
            step($urandom_range(0, 1) != 0 ? pc : pc ^ 32'h4,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                 pc, tgt, $urandom_range(0, 1) != 0, ptk, ptgt);
        end

        drain = 0;
        while (q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/br_predictor.md
Name: br_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Gives fetch a same-cycle taken/target prediction for the current fetch PC.
- Is updated from the execute stage using the resolved outcome from the branch comparator.
- Also flags mispredictions, supplies the redirect PC, and keeps branch/mispredict performance counters.

Parameters:
- DATAW, 32, width of PCs, targets and performance counters.
- ENTRIES, 16, number of BTB entries; must be a power of two, minimum 2.
- IDXW, log2(ENTRIES), index width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- if_pc  input  DATAW  fetch-stage PC to predict.
- pred_taken  output  1  prediction: fetch should follow pred_target.
- pred_target  output  DATAW  predicted target; 0 when pred_taken=0.
- ex_valid  input  1  execute-stage instruction valid (not bubble/flushed).
- ex_is_branch  input  1  execute-stage instruction is a conditional branch.
- ex_pc  input  DATAW  PC of execute-stage branch.
- ex_target  input  DATAW  computed branch target.
- ex_taken  input  1  resolved outcome from comparator.
- ex_pred_taken  input  1  prediction carried down the pipe for this branch.
- ex_pred_target  input  DATAW  predicted target carried down the pipe.
- mispredict  output  1  flush fetch/decode and redirect.
- redirect_pc  output  DATAW  correct next PC when mispredict=1.
- br_count  output  DATAW  resolved branches since reset.
- miss_count  output  DATAW  mispredicted branches since reset.

Behaviour:

Storage and indexing:
- Per entry: valid bit, tag, target (DATAW), 2-bit counter.
- index = pc[IDXW+1:2]; tag = pc[DATAW-1:IDXW+2]; pc[1:0] ignored.

Lookup (combinational from if_pc):
- hit = valid[idx] & (tag[idx] == if_pc tag).
- pred_taken = hit & counter[idx][1].
- pred_target = pred_taken ? target[idx] : 0.

Update enable:
- upd = ex_valid & ex_is_branch.
- All state changes occur on the rising clk edge when upd=1.

Update rules:
- Hit on ex_pc, ex_taken=1: counter saturating increment (11 stays 11); target <= ex_target.
- Hit on ex_pc, ex_taken=0: counter saturating decrement (00 stays 00); target unchanged.
- Miss, ex_taken=1: allocate (overwrite) the entry: valid=1, tag, target=ex_target, counter=10 (weakly taken).
- Miss, ex_taken=0: no change.

Counter encoding:
- 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Mispredict and redirect (combinational):
- mispredict = upd & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & (ex_target != ex_pred_target))).
- redirect_pc = ex_taken ? ex_target : ex_pc + 4 (DATAW-bit, wraps modulo 2^DATAW).
- Both outputs are valid only while mispredict=1; redirect_pc is don't-care otherwise.

Performance counters:
- br_count increments on every upd.
- miss_count increments on every mispredict.
- Both wrap to 0 after all-ones; no saturation.

Boundary conditions:
- Same-cycle read/write to one index: lookup returns the pre-update contents; the new contents are visible the next cycle.
- Aliasing: a different tag at the same index is a miss; a taken resolution evicts the old entry.
- ex_valid=0 or ex_is_branch=0: no state change, mispredict=0, counters unchanged.

Reset (asynchronous, rst=1):
- All valid bits 0, all direction counters 01.
- br_count=0, miss_count=0.
- Tags/targets need no reset.
- Consequences: pred_taken=0, pred_target=0, mispredict is 0 unless upd is asserted combinationally.
- Reset mid-operation discards any in-flight update; outputs reflect the cleared state immediately, not at the next edge.

Test Plan:
- Post-reset lookup: rst pulse, if_pc=0x100 -> pred_taken=0, pred_target=0, br_count=0, miss_count=0.
- Allocate then predict: resolve ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80; miss_count=1, br_count=1.
- Saturation/hysteresis on 0x100 entry:
  - Two taken resolutions -> counter 11.
  - One not-taken -> 10, still predicts taken.
  - Second not-taken -> 01, pred_taken=0.
  - Three more not-taken -> stays 00 (no underflow); one taken -> 01, still predicts not-taken.
- Not-taken mispredict: ex_pc=0x200, ex_pred_taken=1, ex_taken=0 -> mispredict=1, redirect_pc=0x204. Repeat with ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap).
- Wrong target, correct direction: ex_pred_taken=1, ex_taken=1, ex_pred_target=0x40, ex_target=0x60 -> mispredict=1, redirect_pc=0x60, stored target becomes 0x60. Alias ex_pc=0x100+4*ENTRIES taken -> evicts 0x100; lookup of 0x100 then misses.
- Same-cycle read/write and async reset:
  - if_pc=ex_pc=0x300 while allocating -> pred_taken=0 that cycle, 1 next cycle.
  - Assert rst between clock edges -> pred_taken drops to 0 and both counters read 0 without waiting for a clock edge.
  - ex_valid=0 with ex_is_branch=1 -> no count change.
